// File: rtl/seq_left_shifter_if.sv
// Request/result bundle for the sequential left shifter.
// The requester drives the operands and the shifter returns the result with its status.
interface seq_left_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   M;
  logic               busy;
  logic               done;

  modport master (output start, A, shamt, input  M, busy, done);
  modport slave  (input  start, A, shamt, output M, busy, done);
endinterface

// File: rtl/seq_left_shifter.sv
// Iterative barrel shifter: M = A << shamt, one stage per cycle (16, 8, 4, 2, 1).
// Fixed six-cycle latency from the accepting edge to the done pulse.
module seq_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  seq_left_shifter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc, acc_step;
  logic [SHAMT_W-1:0] shamt_q;
  logic [2:0]         stage;
  logic               load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (stage == 3'd0) state_next = DONE;
      end
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        load       = bus.start;
        state_next = bus.start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage k shifts by 2^k when the captured amount has bit k set.
  always_comb begin
    acc_step = acc;
    if (shamt_q[stage]) acc_step = acc << (SHAMT_W'(1) << stage);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath is reset too, since M is observable and must read zero after reset.
      state   <= IDLE;
      acc     <= '0;
      shamt_q <= '0;
      stage   <= 3'd0;
      bus.M   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        acc     <= bus.A;
        shamt_q <= bus.shamt;
        stage   <= 3'd4;
      end else if (state == SHIFT) begin
        acc <= acc_step;
        if (stage == 3'd0) bus.M <= acc_step;
        else               stage <= stage - 3'd1;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed and random checks of seq_left_shifter: latency, result, hold, abort and chaining.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_left_shifter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_m;

  seq_left_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  seq_left_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check all three outputs.
  task automatic check_cycle(input string tag, input logic exp_busy, input logic exp_done,
                             input logic [31:0] exp_m);
    @(negedge clk);
    check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, exp_busy});
    check({tag, ".done"}, {31'd0, bus.done}, {31'd0, exp_done});
    check({tag, ".M"}, bus.M, exp_m);
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                        input logic [31:0] exp_m);
    bus.start = 1'b1;
    bus.A     = a;
    bus.shamt = s;
    for (int c = 1; c <= 5; c++) begin
      check_cycle($sformatf("%s.c%0d", tag, c), 1'b1, 1'b0, last_m);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.shamt = ~s;
      end
    end
    check_cycle($sformatf("%s.c6", tag), 1'b0, 1'b1, exp_m);
    last_m = exp_m;
  endtask

  initial begin
    logic [31:0] ra;
    logic [4:0]  rs;

    reset     = 1'b1;
    bus.start = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    bus.shamt = 5'd7;
    last_m    = 32'h0;
    repeat (2) @(negedge clk);
    check_cycle("reset", 1'b0, 1'b0, 32'h0);
    bus.start = 1'b0;
    reset     = 1'b0;
    check_cycle("idle", 1'b0, 1'b0, 32'h0);

    run_op("one_sh31", 32'h0000_0001, 5'd31, 32'h8000_0000);
    check_cycle("one_sh31.after", 1'b0, 1'b0, last_m);

    run_op("ones_sh16", 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000);
    check_cycle("ones_sh16.after", 1'b0, 1'b0, last_m);
    check_cycle("hold_idle", 1'b0, 1'b0, 32'hFFFF_0000);

    run_op("sh0", 32'h1234_5678, 5'd0, 32'h1234_5678);
    check_cycle("sh0.after", 1'b0, 1'b0, last_m);

    // Start held high through SHIFT with A changing; the done cycle chains a second op.
    bus.start = 1'b1;
    bus.A     = 32'h8000_0001;
    bus.shamt = 5'd1;
    check_cycle("hold.c1", 1'b1, 1'b0, last_m);
    bus.A = 32'hFFFF_FFFF;
    for (int c = 2; c <= 5; c++) check_cycle($sformatf("hold.c%0d", c), 1'b1, 1'b0, last_m);
    check_cycle("hold.c6", 1'b0, 1'b1, 32'h0000_0002);
    last_m = 32'h0000_0002;
    for (int c = 7; c <= 11; c++) begin
      check_cycle($sformatf("hold.c%0d", c), 1'b1, 1'b0, last_m);
      if (c == 7) bus.start = 1'b0;
    end
    check_cycle("hold.c12", 1'b0, 1'b1, 32'hFFFF_FFFE);
    last_m = 32'hFFFF_FFFE;
    check_cycle("hold.after", 1'b0, 1'b0, last_m);

    // Reset in the third SHIFT cycle aborts the operation.
    bus.start = 1'b1;
    bus.A     = 32'hABCD_EF01;
    bus.shamt = 5'd4;
    for (int c = 1; c <= 3; c++) begin
      check_cycle($sformatf("abort.c%0d", c), 1'b1, 1'b0, last_m);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    check_cycle("abort.reset", 1'b0, 1'b0, 32'h0);
    reset  = 1'b0;
    last_m = 32'h0;
    for (int c = 5; c <= 9; c++) check_cycle($sformatf("abort.c%0d", c), 1'b0, 1'b0, 32'h0);
    run_op("post_abort", 32'h0000_0001, 5'd3, 32'h0000_0008);
    check_cycle("post_abort.after", 1'b0, 1'b0, last_m);

    // Back-to-back: second start arrives in the first operation's done cycle.
    run_op("b2b_1", 32'h0000_00FF, 5'd8, 32'h0000_FF00);
    run_op("b2b_2", 32'h0000_0003, 5'd30, 32'hC000_0000);
    check_cycle("b2b.after", 1'b0, 1'b0, last_m);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(31, 0));
      run_op($sformatf("rnd%0d", i), ra, rs, ra << rs);
      check_cycle($sformatf("rnd%0d.after", i), 1'b0, 1'b0, last_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
